// File: rtl/rx_unstuff_if.sv
// Line-side strobe/data inputs and receiver-side serial outputs of the
// receive front end, grouped for one connection.
interface rx_unstuff_if;
    logic bit_strobe;
    logic rx_dp;
    logic rx_dm;
    logic RCS;
    logic RDI;
    logic halt_rx;
    logic rx_eop;
    logic rx_err;

    modport master (
        output bit_strobe, rx_dp, rx_dm,
        input  RCS, RDI, halt_rx, rx_eop, rx_err
    );

    modport slave (
        input  bit_strobe, rx_dp, rx_dm,
        output RCS, RDI, halt_rx, rx_eop, rx_err
    );
endinterface

// File: rtl/rx_unstuff.sv
// Receive front end: NRZI decode, SYNC hunt, bit unstuffing and EOP detection,
// presenting one unstuffed bit per non-halted clock to the downstream shifter.
module rx_unstuff #(
    parameter int MAX_ONES   = 6,
    parameter int SYNC_ZEROS = 5
) (
    input  logic        clock,
    input  logic        reset,
    rx_unstuff_if.slave bus
);
    typedef enum logic [2:0] {HUNT, DATA, EOP, ABORT, ABORT_SE0} state_t;
    typedef enum logic [1:0] {SE0 = 2'b00, LK = 2'b01, LJ = 2'b10, SE1 = 2'b11} line_t;

    localparam logic [2:0] MAX_ONES_C   = 3'(MAX_ONES);
    localparam logic [2:0] SYNC_ZEROS_C = 3'(SYNC_ZEROS);
    localparam logic [2:0] ZERO_SAT     = 3'd7;

    state_t     state;
    logic       prev_j;
    logic [2:0] zero_cnt;
    logic [2:0] ones_cnt;
    logic       rcs;
    logic       rdi;
    logic       halt;
    logic       eop;
    logic       err;

    line_t line;
    logic  is_jk;
    logic  bit_val;

    assign line    = line_t'({bus.rx_dp, bus.rx_dm});
    assign is_jk   = (line == LJ) || (line == LK);
    assign bit_val = ((line == LJ) == prev_j);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= HUNT;
            prev_j   <= 1'b1;
            zero_cnt <= '0;
            ones_cnt <= '0;
            rcs      <= 1'b0;
            rdi      <= 1'b0;
            halt     <= 1'b0;
            eop      <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: defaults first; a later non-blocking assignment in the same block overrides them.
            eop  <= 1'b0;
            err  <= 1'b0;
            halt <= rcs;
            if (bus.bit_strobe) begin
                halt <= 1'b0;
                if (is_jk) prev_j <= (line == LJ);
                case (state)
                    HUNT: begin
                        rcs <= 1'b0;
                        if (!is_jk) begin
                            zero_cnt <= '0;
                            prev_j   <= 1'b1;
                        end else if (!bit_val) begin
                            if (zero_cnt != ZERO_SAT) zero_cnt <= zero_cnt + 3'd1;
                        end else if (zero_cnt >= SYNC_ZEROS_C) begin
                            // The closing SYNC 1 already counts toward the stuffing run.
                            state    <= DATA;
                            ones_cnt <= 3'd1;
                            zero_cnt <= '0;
                        end else begin
                            zero_cnt <= '0;
                        end
                    end
                    DATA: begin
                        case (line)
                            SE0: begin
                                state <= EOP;
                                rcs   <= 1'b0;
                            end
                            SE1: begin
                                state <= ABORT;
                                rcs   <= 1'b0;
                                err   <= 1'b1;
                            end
                            default: begin
                                if (ones_cnt == MAX_ONES_C) begin
                                    if (bit_val) begin
                                        state <= ABORT;
                                        rcs   <= 1'b0;
                                        err   <= 1'b1;
                                    end else begin
                                        rcs      <= 1'b1;
                                        halt     <= 1'b1;
                                        ones_cnt <= '0;
                                    end
                                end else begin
                                    rcs      <= 1'b1;
                                    rdi      <= bit_val;
                                    ones_cnt <= bit_val ? ones_cnt + 3'd1 : 3'd0;
                                end
                            end
                        endcase
                    end
                    EOP: begin
                        rcs <= 1'b0;
                        if (line == LJ) begin
                            state    <= HUNT;
                            eop      <= 1'b1;
                            prev_j   <= 1'b1;
                            zero_cnt <= '0;
                        end else if (line != SE0) begin
                            state <= ABORT;
                            err   <= 1'b1;
                        end
                    end
                    ABORT: begin
                        rcs <= 1'b0;
                        if (line == SE0) state <= ABORT_SE0;
                    end
                    ABORT_SE0: begin
                        rcs <= 1'b0;
                        if (line == LJ) begin
                            state    <= HUNT;
                            prev_j   <= 1'b1;
                            zero_cnt <= '0;
                        end else if (line != SE0) begin
                            state <= ABORT;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        rcs   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.RCS     = rcs;
    assign bus.RDI     = rdi;
    assign bus.halt_rx = halt;
    assign bus.rx_eop  = eop;
    assign bus.rx_err  = err;
endmodule

// File: tb/tb_rx_unstuff.sv
// Bench for rx_unstuff: packets are built by a line encoder (SYNC, stuffing,
// NRZI, EOP) and the delivered bit stream is compared with the payload.
module tb_rx_unstuff;
    localparam logic [1:0] SJ = 2'b10, SK = 2'b01, S0 = 2'b00, S1 = 2'b11;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rx_unstuff_if bus ();
    rx_unstuff dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: collects delivered bits and event counts on every clock.
    logic got_q[$];
    int   stuff_cnt = 0, eop_cnt = 0, err_cnt = 0, viol_cnt = 0;
    logic strobe_q, reset_q;

    always @(posedge clock) begin
        strobe_q <= bus.bit_strobe;
        reset_q  <= reset;
    end

    always @(negedge clock) begin
        if (reset_q === 1'b1) begin
            if (bus.RCS && !bus.halt_rx) got_q.push_back(bus.RDI);
            if (strobe_q && bus.RCS && bus.halt_rx) stuff_cnt++;
            if (bus.rx_eop) eop_cnt++;
            if (bus.rx_err) err_cnt++;
            if (!strobe_q && (bus.halt_rx !== bus.RCS || bus.rx_eop || bus.rx_err)) viol_cnt++;
        end
    end

    // Line encoder state
    logic [1:0] sym_q[$];
    logic       exp_q[$];
    logic       enc_j;
    int         enc_ones;
    int         exp_stuffs;

    logic o_rcs, o_rdi, o_halt, o_eop, o_err;

    task automatic push_level(input logic j);
        sym_q.push_back(j ? SJ : SK);
    endtask

    task automatic add_sync();
        sym_q.push_back(SK); sym_q.push_back(SJ); sym_q.push_back(SK); sym_q.push_back(SJ);
        sym_q.push_back(SK); sym_q.push_back(SJ); sym_q.push_back(SK); sym_q.push_back(SK);
        enc_j    = 1'b0;
        enc_ones = 1;
    endtask

    task automatic add_bit(input logic b);
        exp_q.push_back(b);
        if (b) enc_ones++;
        else begin
            enc_j    = ~enc_j;
            enc_ones = 0;
        end
        push_level(enc_j);
        if (enc_ones == 6) begin
            enc_j    = ~enc_j;
            enc_ones = 0;
            exp_stuffs++;
            push_level(enc_j);
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) add_bit(b[i]);
    endtask

    task automatic add_eop();
        sym_q.push_back(S0); sym_q.push_back(S0); sym_q.push_back(SJ);
    endtask

    task automatic send_sym(input logic [1:0] s, input int gap);
        bus.bit_strobe = 1'b1;
        {bus.rx_dp, bus.rx_dm} = s;
        @(negedge clock);
        o_rcs  = bus.RCS;
        o_rdi  = bus.RDI;
        o_halt = bus.halt_rx;
        o_eop  = bus.rx_eop;
        o_err  = bus.rx_err;
        bus.bit_strobe = 1'b0;
        {bus.rx_dp, bus.rx_dm} = SJ;
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic send_queue(input int gmin, input int gmax);
        while (sym_q.size() > 0) send_sym(sym_q.pop_front(), int'($urandom_range(gmax, gmin)));
    endtask

    task automatic idle(input int n);
        repeat (n) send_sym(SJ, 2);
    endtask

    task automatic start_frame();
        sym_q.delete();
        exp_q.delete();
        got_q.delete();
        exp_stuffs = 0;
    endtask

    task automatic run_packet(input string tag, input int nbytes, input logic [31:0] data,
                              input int gmin, input int gmax);
        int          s0, e0, r0, v0;
        logic [7:0]  gb, eb;
        start_frame();
        s0 = stuff_cnt; e0 = eop_cnt; r0 = err_cnt; v0 = viol_cnt;
        add_sync();
        for (int i = 0; i < nbytes; i++) add_byte(data[i*8 +: 8]);
        add_eop();
        send_queue(gmin, gmax);
        idle(2);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < nbytes; i++) begin
            for (int j = 0; j < 8; j++) begin
                eb[j] = exp_q[i*8 + j];
                gb[j] = (i*8 + j < got_q.size()) ? got_q[i*8 + j] : 1'bx;
            end
            check({tag, "_byte"}, gb, eb);
        end
        check({tag, "_stuffs"}, stuff_cnt - s0, exp_stuffs);
        check({tag, "_eop"}, eop_cnt - e0, 1);
        check({tag, "_err"}, err_cnt - r0, 0);
        check({tag, "_halt_rule"}, viol_cnt - v0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          e0, r0, v0, n0;
        logic [7:0]  a5;
        logic [31:0] rnd;
        int          nb;

        bus.bit_strobe = 1'b0;
        {bus.rx_dp, bus.rx_dm} = SJ;
        repeat (3) @(negedge clock);
        check("reset_outs", {bus.RCS, bus.RDI, bus.halt_rx, bus.rx_eop, bus.rx_err}, 5'b0);
        reset = 1'b1;
        @(negedge clock);

        // Directed SYNC + 0xA5 at one strobe every 4 clocks
        start_frame();
        e0 = eop_cnt; v0 = viol_cnt;
        a5 = 8'hA5;
        add_sync();
        add_byte(a5);
        add_eop();
        for (int i = 0; i < 8; i++) send_sym(sym_q.pop_front(), 4);
        check("a5_rcs_after_sync", o_rcs, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_sym(sym_q.pop_front(), 4);
            check("a5_rcs_halt", {o_rcs, o_halt}, 2'b10);
            check("a5_rdi", o_rdi, a5[i]);
        end
        send_sym(sym_q.pop_front(), 4);
        check("a5_rcs_fall_se0", o_rcs, 1'b0);
        send_sym(sym_q.pop_front(), 4);
        send_sym(sym_q.pop_front(), 4);
        check("a5_eop_pulse", o_eop, 1'b1);
        idle(2);
        check("a5_eop_once", eop_cnt - e0, 1);
        check("a5_halt_rule", viol_cnt - v0, 0);
        check("a5_bits", got_q.size(), 8);

        // Stuffing across a byte boundary
        run_packet("stuff", 2, 32'h0000_01FF, 4, 4);

        // Stuff error: seven decoded 1s after SYNC
        start_frame();
        e0 = eop_cnt; r0 = err_cnt;
        add_sync();
        for (int i = 0; i < 5; i++) sym_q.push_back(SK);
        send_queue(3, 3);
        send_sym(SK, 3);
        check("stufferr_err", o_err, 1'b1);
        check("stufferr_rcs", o_rcs, 1'b0);
        send_sym(SK, 3);
        add_sync();
        add_byte(8'h5A);
        send_queue(1, 3);
        sym_q.push_back(S0); sym_q.push_back(SJ);
        send_queue(2, 2);
        idle(2);
        check("stufferr_bits", got_q.size(), 5);
        check("stufferr_errcnt", err_cnt - r0, 1);
        check("stufferr_no_eop", eop_cnt - e0, 0);
        run_packet("after_stufferr", 1, 32'h0000_0033, 2, 4);

        // Weak SYNC must not open a packet
        start_frame();
        e0 = eop_cnt;
        sym_q = '{SK, SJ, SK, SK, SK, SK, SJ, SK};
        send_queue(2, 3);
        idle(3);
        check("weak_bits", got_q.size(), 0);
        check("weak_eop", eop_cnt - e0, 0);
        run_packet("after_weak", 1, 32'h0000_00C3, 2, 4);

        // Reset in the middle of a packet
        start_frame();
        e0 = eop_cnt; r0 = err_cnt;
        add_sync();
        add_bit(1'b1); add_bit(1'b0); add_bit(1'b1);
        send_queue(3, 3);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("midrst_outs", {bus.RCS, bus.RDI, bus.halt_rx, bus.rx_eop, bus.rx_err}, 5'b0);
        idle(2);
        check("midrst_no_eop", eop_cnt - e0, 0);
        check("midrst_no_err", err_cnt - r0, 0);
        run_packet("after_midrst", 2, 32'h0000_7E81, 1, 3);

        // SE1 during DATA
        start_frame();
        e0 = eop_cnt; r0 = err_cnt;
        add_sync();
        add_bit(1'b1); add_bit(1'b0);
        send_queue(2, 2);
        send_sym(S1, 2);
        check("se1_err", o_err, 1'b1);
        check("se1_rcs", o_rcs, 1'b0);
        n0 = got_q.size();
        add_sync();
        add_byte(8'h3C);
        send_queue(1, 3);
        idle(2);
        check("se1_ignored", got_q.size(), n0);
        sym_q.push_back(S0); sym_q.push_back(SJ);
        send_queue(2, 2);
        idle(2);
        check("se1_errcnt", err_cnt - r0, 1);
        check("se1_no_eop", eop_cnt - e0, 0);
        run_packet("after_se1", 1, 32'h0000_00E7, 1, 4);

        // Randomised packets, weighted toward long runs of ones
        for (int p = 0; p < 25; p++) begin
            nb = int'($urandom_range(4, 1));
            for (int b = 0; b < 4; b++)
                rnd[b*8 +: 8] = ($urandom_range(2, 0) == 0) ? 8'hFF : 8'($urandom);
            run_packet("rand", nb, rnd, 1, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_unstuff.md
Name: rx_unstuff

Overview:
- Receive front end between the line sampler/DPLL and the serial-to-parallel receiver.
- Takes the sampled differential line state plus a per-bit strobe, and performs NRZI decoding, SYNC detection, bit-unstuffing and EOP detection.
- Drives RCS/RDI/halt_rx so that the downstream shifter gets exactly one data bit per non-halted clock while a packet is active.
- Dropping RCS marks end of packet, which the downstream receiver uses to flag the last byte.

Parameters:
- MAX_ONES, 6, consecutive decoded 1s after which the next bit must be a stuffed 0.
- SYNC_ZEROS, 5, minimum consecutive decoded 0s in HUNT before the terminating 1 is accepted as end of SYNC.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- bit_strobe  in  1  one-clock pulse per received bit time; rx_dp/rx_dm are valid when high.
- rx_dp  in  1  sampled D+ line.
- rx_dm  in  1  sampled D- line.
- RCS  out  1  high from first payload bit to EOP; downstream shifts RDI when RCS=1 and halt_rx=0.
- RDI  out  1  decoded, unstuffed serial data bit (LSB first, as received).
- halt_rx  out  1  high on clocks when RCS=1 but no new payload bit is presented (no strobe, or stuffed bit dropped).
- rx_eop  out  1  one-clock pulse when a valid EOP (SE0 then J) completes.
- rx_err  out  1  one-clock pulse on stuff error or SE1 during a packet.

Behaviour:
- Line decode at each strobe:
  - J = (dp,dm)=(1,0); K = (0,1); SE0 = (0,0); SE1 = (1,1).
  - NRZI: decoded bit = 1 if the J/K level equals prev_level, else 0.
  - prev_level updates only on J/K strobes; it is forced to J on reset and on every entry to HUNT.
- All outputs are registered; strobe-to-output latency is exactly 1 clock.
- Clocks without a strobe change no state. Outputs on those clocks:
  - RCS holds.
  - halt_rx = RCS.
  - rx_eop = 0, rx_err = 0.
- Reset (reset=0 at posedge, any state, including mid-packet):
  - state=HUNT, prev_level=J, all counters 0.
  - RCS=0, RDI=0, halt_rx=0, rx_eop=0, rx_err=0.
  - A packet in progress is abandoned with no EOP or error pulse.
- HUNT:
  - Counts consecutive decoded 0s, saturating at 7.
  - Decoded 1 with zero_cnt >= SYNC_ZEROS: go to DATA with ones_cnt=1 (the final SYNC bit counts toward stuffing). RCS stays 0 this clock.
  - Decoded 1 with zero_cnt < SYNC_ZEROS: zero_cnt=0.
  - SE0/SE1: zero_cnt=0, prev_level=J, stay in HUNT.
- DATA, J/K strobe:
  - ones_cnt == MAX_ONES and bit 0: stuffed bit. Output RCS=1, halt_rx=1; RDI holds; ones_cnt=0.
  - ones_cnt == MAX_ONES and bit 1: stuff error. Output rx_err=1, RCS=0, halt_rx=0; go to ABORT.
  - Otherwise: output RCS=1, halt_rx=0, RDI=bit. ones_cnt = bit ? ones_cnt+1 : 0.
- DATA, SE0 strobe: go to EOP. Output RCS=0, halt_rx=0. This is the last-byte indication to downstream.
- DATA, SE1 strobe: rx_err=1, RCS=0; go to ABORT.
- EOP:
  - SE0 strobe: stay.
  - J strobe: rx_eop=1; go to HUNT.
  - K or SE1 strobe: rx_err=1; go to ABORT.
- ABORT:
  - RCS=0.
  - Ignores data until an SE0 strobe followed by a J strobe, then goes to HUNT. No rx_eop is issued on this exit.
- Simultaneous events: the reset condition wins over everything. Priority of a stuff error and SE0 on the same strobe is not a case: SE0 is not a J/K bit and is handled as EOP.
- Payload bit count is not checked here; byte alignment is the downstream counter's job.

Test Plan:
- Sync plus byte: line KJKJKJKK, then NRZI of byte 0xA5 LSB first, then SE0,SE0,J, one strobe every 4 clocks.
  - Expect RCS to rise 1 clock after the 9th strobe.
  - Expect RDI sequence 1,0,1,0,0,1,0,1, each with halt_rx=0 on the strobe+1 clock and halt_rx=1 otherwise.
  - Expect RCS to fall on the first SE0, and rx_eop=1 exactly once, 1 clock after the J.
- Stuffing: payload 0xFF then 0x01 (after SYNC the ones run starts at 1).
  - Expect a stuffed 0 after the 5th payload 1, dropped with halt_rx=1 and no RDI change.
  - Expect 16 payload bits delivered and 0 errors.
- Stuff error: seven consecutive decoded 1s after SYNC with no stuffed 0.
  - Expect rx_err pulse, RCS=0, all strobes ignored until SE0,J, then a fresh SYNC is accepted.
- Weak sync: only 3 KJ transitions before KK.
  - Expect RCS to stay 0.
  - A following full sync is accepted normally.
- Reset mid-packet: drive reset=0 for 1 clock after 3 payload bits.
  - Expect all outputs 0 on the next clock, no rx_eop, no rx_err, and HUNT re-entered.
- SE1 during DATA: expect rx_err=1, RCS=0, and recovery only after SE0 then J.
